// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Issues word-aligned requests to an instruction
// memory with a request/ready handshake and fills a single IF/ID slot for the
// decoder. A one-entry buffer catches a response that lands while the decoder
// is stalled, so no fetched word is lost or re-fetched. Redirects (branch,
// jump, iret, exception) take priority over stall and over returning data.
// A redirect that arrives while a request is still outstanding cannot cancel
// that request, so the old request is drained and its data thrown away.
//
// Parameters
//   RESET_PC   first fetch address after reset
//   NOP_INSTR  encoding driven on if_instr whenever if_valid=0
//
// Ports
//   clk             single clock, rising edge
//   rst             synchronous reset, active low
//   stall           decoder not accepting; IF/ID slot frozen
//   redirect_valid  redirect_pc is a new fetch target this cycle
//   redirect_pc     redirect target, bits [1:0] ignored
//   imem_req        request to instruction memory
//   imem_addr       request address, word aligned
//   imem_ready      response valid, completes the outstanding request
//   imem_rdata      instruction word, valid with imem_ready
//   if_valid        IF/ID slot holds a real instruction
//   if_instr        instruction to decode (NOP_INSTR when if_valid=0)
//   if_pc           address of if_instr
//
// State     | meaning
// ----------+-----------------------------------------------------------------
// S_IDLE    | one cycle after reset release, no request issued
// S_FETCH   | request for pc outstanding
// S_DRAIN   | redirected while a request was outstanding; finish and discard
// S_BLOCKED | response captured in the buffer during a stall, no request
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DRAIN   = 2'd2,
    S_BLOCKED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;

  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;

  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  // Plain 32-bit add: wraps from 32'hFFFF_FFFC to 32'h0000_0000 silently.
  assign pc_plus4        = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      buf_valid_q  <= 1'b0;
      buf_instr_q  <= NOP_INSTR;
      buf_pc_q     <= 32'h0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_valid_q  <= buf_valid_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_valid_d  = buf_valid_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    imem_req     = 1'b0;
    imem_addr    = pc_q;

    // Request outputs depend only on state, so they stay stable for the
    // whole life of a request regardless of what happens to pc meanwhile.
    case (state_q)
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
      end
      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
      end
    endcase

    if (redirect_valid) begin
      // Redirect wins over stall and over any data returning this cycle.
      pc_d        = redirect_target;
      buf_valid_d = 1'b0;
      if_valid_d  = 1'b0;
      if_instr_d  = NOP_INSTR;
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            state_d = S_FETCH;
          end else begin
            // The live request cannot be withdrawn; remember its address.
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end
        end
        S_DRAIN: begin
          // drain_addr_q keeps the address of the request still in flight.
          state_d = imem_ready ? S_FETCH : S_DRAIN;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
          if (!stall) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
          end
        end

        S_FETCH: begin
          if (imem_ready) begin
            pc_d = pc_plus4;
            if (stall) begin
              // Decoder busy: park the word, stop requesting until it drains.
              buf_valid_d = 1'b1;
              buf_instr_d = imem_rdata;
              buf_pc_d    = pc_q;
              state_d     = S_BLOCKED;
            end else begin
              if_valid_d = 1'b1;
              if_instr_d = imem_rdata;
              if_pc_d    = pc_q;
            end
          end else if (!stall) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
          end
        end

        S_DRAIN: begin
          // Data from the abandoned request is never forwarded.
          if (imem_ready) begin
            state_d = S_FETCH;
          end
          if (!stall) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
          end
        end

        S_BLOCKED: begin
          if (!stall) begin
            if_valid_d  = 1'b1;
            if_instr_d  = buf_instr_q;
            if_pc_d     = buf_pc_q;
            buf_valid_d = 1'b0;
            state_d     = S_FETCH;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  // 0: zero-wait (ready tied high), 1: fixed latency mem_lat, 2: random latency
  int mem_mode = 0;
  int mem_lat  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural instruction stream from a start address: consecutive words,
  // 32-bit wrap, each word is whatever memory holds at that address.
  task automatic push_stream(input logic [31:0] start);
    logic [31:0] a;
    exp_t e;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 512; i++) begin
      e.pc    = a;
      e.instr = mem_word(a);
      exp_q.push_back(e);
      a = a + 32'd4;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    logic [31:0] aligned;
    aligned        = {t[31:2], 2'b00};
    redirect_valid = 1'b1;
    redirect_pc    = t;
    @(posedge clk);
    push_stream(aligned);
    #1;
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
  endtask

  task automatic hold_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    exp_q.delete();
    #1;
  endtask

  task automatic release_reset();
    rst = 1'b1;
    push_stream(RESET_PC);
  endtask

  task automatic check_reset_values(input string tag);
    check1 ({tag, "_req"},   imem_req,  1'b0);
    check32({tag, "_addr"},  imem_addr, RESET_PC);
    check1 ({tag, "_valid"}, if_valid,  1'b0);
    check32({tag, "_instr"}, if_instr,  NOP);
    check32({tag, "_pc"},    if_pc,     32'h0);
  endtask

  // Memory model
  initial begin
    bit busy;
    int wait_left;
    busy       = 1'b0;
    wait_left  = 0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst !== 1'b1) begin
        busy       = 1'b0;
        imem_ready = ($urandom_range(0, 1) == 1);
        imem_rdata = $urandom;
      end else if (mem_mode == 0) begin
        busy       = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else if (imem_req) begin
        if (!busy) begin
          busy      = 1'b1;
          wait_left = (mem_mode == 1) ? mem_lat : $urandom_range(0, 3);
        end
        if (wait_left == 0) begin
          imem_ready = 1'b1;
          imem_rdata = mem_word(imem_addr);
          busy       = 1'b0;
        end else begin
          imem_ready = 1'b0;
          imem_rdata = $urandom;
          wait_left--;
        end
      end else begin
        imem_ready = 1'b0;
        imem_rdata = $urandom;
      end
    end
  end

  // Request protocol monitor: a pending request must hold until ready.
  initial begin
    bit          p_req, p_rdy, p_rst;
    logic [31:0] p_addr;
    p_req  = 1'b0;
    p_rdy  = 1'b0;
    p_rst  = 1'b0;
    p_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (p_rst && p_req && !p_rdy) begin
        check1 ("req_held",  imem_req,  1'b1);
        check32("addr_held", imem_addr, p_addr);
      end
      if (imem_req === 1'b1)
        check32("addr_aligned", {30'b0, imem_addr[1:0]}, 32'h0);
      p_req  = (imem_req === 1'b1);
      p_rdy  = (imem_ready === 1'b1);
      p_rst  = (rst === 1'b1);
      p_addr = imem_addr;
    end
  end

  // Scoreboard: every instruction the decoder accepts must be the next one
  // of the expected stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && if_valid === 1'b1 && stall === 1'b0) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stream_underflow: got pc %h, expected nothing", if_pc);
        end else begin
          e = exp_q.pop_front();
          check32("stream_pc",    if_pc,    e.pc);
          check32("stream_instr", if_instr, e.instr);
        end
      end
      if (if_valid === 1'b0)
        check32("nop_when_invalid", if_instr, NOP);
    end
  end

  // Stimulus
  initial begin
    bit          found;
    int          r;
    logic [31:0] t;

    rst            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_values("reset");

    // Zero-wait streaming: one fetch per cycle, one cycle latency
    cyc();
    release_reset();
    @(negedge clk);
    check1 ("idle_req",  imem_req,  1'b0);
    check32("idle_addr", imem_addr, RESET_PC);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1 ("seq_req",  imem_req,  1'b1);
      check32("seq_addr", imem_addr, RESET_PC + 32'(4 * i));
      if (i > 0) begin
        check1 ("seq_valid", if_valid, 1'b1);
        check32("seq_if_pc", if_pc,    RESET_PC + 32'(4 * (i - 1)));
        check32("seq_instr", if_instr, mem_word(RESET_PC + 32'(4 * (i - 1))));
      end
    end

    // Stall for 3 cycles while the response to 0x1010 arrives
    cyc();
    stall = 1'b1;
    @(negedge clk);
    check32("stall_addr",  imem_addr, RESET_PC + 32'd16);
    check32("stall_if_pc", if_pc,     RESET_PC + 32'd12);
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      check1 ("blocked_req",   imem_req, 1'b0);
      check1 ("blocked_valid", if_valid, 1'b1);
      check32("blocked_if_pc", if_pc,    RESET_PC + 32'd12);
    end
    cyc();
    stall = 1'b0;
    @(negedge clk);
    check1 ("unblock_req",   imem_req, 1'b0);
    check32("unblock_if_pc", if_pc,    RESET_PC + 32'd12);
    @(negedge clk);
    check32("buffered_pc",    if_pc,     RESET_PC + 32'd16);
    check32("buffered_instr", if_instr,  mem_word(RESET_PC + 32'd16));
    check32("resume_addr",    imem_addr, RESET_PC + 32'd20);

    // Redirect to 0x2002 while a 3-cycle request to 0x1010 is outstanding
    mem_mode = 1;
    mem_lat  = 2;
    cyc();
    hold_reset(2);
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && imem_addr === RESET_PC + 32'd16) found = 1'b1;
    end
    check1("drain_setup_found", found, 1'b1);
    cyc();
    do_redirect(32'h0000_2002);
    @(negedge clk);
    check1 ("drain_req",   imem_req,  1'b1);
    check32("drain_addr",  imem_addr, RESET_PC + 32'd16);
    check1 ("drain_valid", if_valid,  1'b0);
    @(negedge clk);
    check32("post_drain_addr",  imem_addr, 32'h0000_2000);
    check1 ("post_drain_valid", if_valid,  1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1) found = 1'b1;
    end
    check1 ("first_after_drain_seen", found, 1'b1);
    check32("first_after_drain_pc",   if_pc, 32'h0000_2000);

    // Redirect + ready in the same cycle, with stall
    mem_mode = 0;
    cyc();
    stall = 1'b1;
    do_redirect(32'h0000_3001);
    @(negedge clk);
    check1 ("redir_stall_valid", if_valid,  1'b0);
    check32("redir_stall_instr", if_instr,  32'h0000_0013);
    check32("redir_stall_addr",  imem_addr, 32'h0000_3000);
    cyc();
    stall = 1'b0;

    // pc wrap
    do_redirect(32'hFFFF_FFFE);
    @(negedge clk);
    check32("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check32("wrap_addr1", imem_addr, 32'h0000_0000);
    check32("wrap_if_pc", if_pc,     32'hFFFF_FFFC);

    // Reset during DRAIN
    mem_mode = 1;
    mem_lat  = 4;
    cyc();
    hold_reset(1);
    release_reset();
    cyc();
    do_redirect(32'h0000_5000);
    @(negedge clk);
    check1 ("pre_reset_drain_req",  imem_req,  1'b1);
    check32("pre_reset_drain_addr", imem_addr, RESET_PC);
    cyc();
    hold_reset(1);
    @(negedge clk);
    check_reset_values("rst_drain");
    cyc();
    release_reset();
    @(negedge clk);
    @(negedge clk);
    check1 ("rst_drain_first_req",  imem_req,  1'b1);
    check32("rst_drain_first_addr", imem_addr, RESET_PC);

    // Reset during BLOCKED
    mem_mode = 0;
    cyc();
    cyc();
    stall = 1'b1;
    cyc();
    @(negedge clk);
    check1("pre_reset_blocked_req", imem_req, 1'b0);
    cyc();
    hold_reset(1);
    @(negedge clk);
    check_reset_values("rst_blocked");
    cyc();
    stall = 1'b0;
    release_reset();
    @(negedge clk);
    @(negedge clk);
    check1 ("rst_blocked_first_req",  imem_req,  1'b1);
    check32("rst_blocked_first_addr", imem_addr, RESET_PC);

    // Randomized traffic
    mem_mode = 2;
    cyc();
    for (int n = 0; n < 4000; n++) begin
      r     = $urandom_range(0, 199);
      stall = ($urandom_range(0, 3) == 0);
      if (r == 0) begin
        hold_reset($urandom_range(1, 2));
        release_reset();
        cyc();
      end else if (r < 14) begin
        t = $urandom;
        if (r < 3) t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
        do_redirect(t);
      end else begin
        cyc();
      end
    end
    stall = 1'b0;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
